// File: rtl/id_stage_if.sv
// Bus between the fetch/write-back/EX side of the pipeline and the decode stage.
// master drives fetch, write-back and hazard inputs; slave (id_stage) drives decode results.
interface id_stage_if;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        pc_write;
  logic        id_bubble;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [31:0] jump_addr;

  modport master (
    output if_pc_plus4, if_inst, flush, wb_reg_write, wb_rd, wb_data, ex_mem_read, ex_rt,
    input  pc_write, id_bubble, id_valid, id_pc_plus4, opcode, rs, rt, rd, shamt, funct,
           rs_data, rt_data, imm_ext, jump_addr
  );

  modport slave (
    input  if_pc_plus4, if_inst, flush, wb_reg_write, wb_rd, wb_data, ex_mem_read, ex_rt,
    output pc_write, id_bubble, id_valid, id_pc_plus4, opcode, rs, rt, rd, shamt, funct,
           rs_data, rt_data, imm_ext, jump_addr
  );
endinterface

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file with write-through,
// immediate extension and load-use hazard detection.
module id_stage (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);

  logic [31:0] inst;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] regs [0:31];
  logic        stall;
  logic        uses_rt;
  logic        wb_en;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;

  assign rs_idx = inst[25:21];
  assign rt_idx = inst[20:16];
  assign wb_en  = bus.wb_reg_write && (bus.wb_rd != 5'd0);

  // Stall/flush handshake: pc_write low means fetch holds if_pc_plus4/if_inst and the
  // IF/ID register holds too; flush overrides stall and loads a NOP with id_valid low.
  always_comb begin
    uses_rt = 1'b0;
    case (inst[31:26])
      6'h00, 6'h04, 6'h05, 6'h2b: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  assign stall = valid_q && bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                 ((bus.ex_rt == rs_idx) || (uses_rt && (bus.ex_rt == rt_idx))) &&
                 !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      inst    <= '0;
      pc_q    <= bus.if_pc_plus4;
      valid_q <= 1'b0;
    end else if (!stall) begin
      inst    <= bus.if_inst;
      pc_q    <= bus.if_pc_plus4;
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Same-cycle write-back is forwarded so ID never reads a stale operand.
  always_comb begin
    bus.rs_data = regs[rs_idx];
    if (rs_idx == 5'd0) bus.rs_data = '0;
    else if (wb_en && (bus.wb_rd == rs_idx)) bus.rs_data = bus.wb_data;
  end

  always_comb begin
    bus.rt_data = regs[rt_idx];
    if (rt_idx == 5'd0) bus.rt_data = '0;
    else if (wb_en && (bus.wb_rd == rt_idx)) bus.rt_data = bus.wb_data;
  end

  always_comb begin
    bus.imm_ext = {{16{inst[15]}}, inst[15:0]};
    case (inst[31:26])
      6'h0c, 6'h0d, 6'h0e: bus.imm_ext = {16'h0000, inst[15:0]};
      default:             bus.imm_ext = {{16{inst[15]}}, inst[15:0]};
    endcase
  end

  assign bus.pc_write    = !stall;
  assign bus.id_bubble   = stall || !valid_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_pc_plus4 = pc_q;
  assign bus.opcode      = inst[31:26];
  assign bus.rs          = rs_idx;
  assign bus.rt          = rt_idx;
  assign bus.rd          = inst[15:11];
  assign bus.shamt       = inst[10:6];
  assign bus.funct       = inst[5:0];
  assign bus.jump_addr   = {pc_q[31:28], inst[25:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: spec-level model checked every negedge, plus literal
// expectations at the key points of each scenario.
module tb_id_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_stage_if bus ();

  id_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_regs [0:31];

  task automatic model_reset();
    m_inst  = '0;
    m_pc    = '0;
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic model_stall();
    logic [5:0] op;
    logic       rt_used;
    logic       hit;
    op      = m_inst[31:26];
    rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
    hit     = (bus.ex_rt == m_inst[25:21]) || (rt_used && bus.ex_rt == m_inst[20:16]);
    return m_valid && bus.ex_mem_read && (bus.ex_rt != 0) && hit && !bus.flush;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int unsigned v;
    v = i[15:0];
    if (i[31:26] == 6'h0c || i[31:26] == 6'h0d || i[31:26] == 6'h0e) return v;
    if (v >= 32768) return v + 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      logic st;
      st = model_stall();
      if (bus.wb_reg_write && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
      if (bus.flush) begin
        m_inst = '0; m_valid = 1'b0; m_pc = bus.if_pc_plus4;
      end else if (!st) begin
        m_inst = bus.if_inst; m_valid = 1'b1; m_pc = bus.if_pc_plus4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic st;
    st = model_stall();
    check("cyc_pc_write",  32'(bus.pc_write),  32'(!st));
    check("cyc_id_bubble", 32'(bus.id_bubble), 32'(st || !m_valid));
    check("cyc_id_valid",  32'(bus.id_valid),  32'(m_valid));
    check("cyc_pc_plus4",  bus.id_pc_plus4,    m_pc);
    check("cyc_opcode",    32'(bus.opcode),    32'(m_inst / 32'h0400_0000));
    check("cyc_rs",        32'(bus.rs),        (m_inst >> 21) % 32);
    check("cyc_rt",        32'(bus.rt),        (m_inst >> 16) % 32);
    check("cyc_rd",        32'(bus.rd),        (m_inst >> 11) % 32);
    check("cyc_shamt",     32'(bus.shamt),     (m_inst >> 6) % 32);
    check("cyc_funct",     32'(bus.funct),     m_inst % 64);
    check("cyc_rs_data",   bus.rs_data,        model_read(m_inst[25:21]));
    check("cyc_rt_data",   bus.rt_data,        model_read(m_inst[20:16]));
    check("cyc_imm_ext",   bus.imm_ext,        model_imm(m_inst));
    check("cyc_jump_addr", bus.jump_addr,
          (m_pc & 32'hF000_0000) + ((m_inst % 32'h0400_0000) * 4));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_inst     = inst;
    bus.if_pc_plus4 = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.if_pc_plus4 = '0; bus.if_inst = '0; bus.flush = 1'b0;
    bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
    model_reset();
    #1;
    check("rst_pc_write",  32'(bus.pc_write),  32'd1);
    check("rst_id_bubble", 32'(bus.id_bubble), 32'd1);
    check("rst_id_valid",  32'(bus.id_valid),  32'd0);
    check("rst_opcode",    32'(bus.opcode),    32'd0);
    check("rst_imm_ext",   bus.imm_ext,        32'd0);
    tick();
    tick();

    // reset then run: addi $8,$0,5
    rst_n = 1'b1;
    fetch(32'h2008_0005, 32'd4);
    tick();
    check("addi_opcode", 32'(bus.opcode),    32'h08);
    check("addi_rt",     32'(bus.rt),        32'd8);
    check("addi_imm",    bus.imm_ext,        32'h0000_0005);
    check("addi_valid",  32'(bus.id_valid),  32'd1);
    check("addi_bubble", 32'(bus.id_bubble), 32'd0);
    check("addi_pc",     bus.id_pc_plus4,    32'd4);

    // sign vs zero extension
    fetch(32'h2009_FFFF, 32'd8);
    tick();
    check("sext_imm", bus.imm_ext, 32'hFFFF_FFFF);
    fetch(32'h3409_FFFF, 32'd12);
    tick();
    check("zext_imm", bus.imm_ext, 32'h0000_FFFF);

    // jump target uses PC+4 upper nibble
    fetch(32'h0810_0004, 32'h9000_0010);
    tick();
    check("jump_addr", bus.jump_addr, 32'h9040_0010);

    // write-through on rs = 9
    fetch(32'h012B_5020, 32'h20);
    tick();
    check("add_rd",      32'(bus.rd),    32'd10);
    check("add_funct",   32'(bus.funct), 32'h20);
    check("add_rs_pre",  bus.rs_data,    32'd0);
    bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    check("bypass_rs", bus.rs_data, 32'hDEAD_BEEF);
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    check("persist_rs", bus.rs_data, 32'hDEAD_BEEF);

    // write to register 11 for rt operand
    bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 32'h0000_1111;
    #1;
    check("bypass_rt", bus.rt_data, 32'h0000_1111);
    tick();
    bus.wb_reg_write = 1'b0;

    // write to register 0 is ignored
    fetch(32'h2008_0005, 32'h24);
    tick();
    bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1234;
    #1;
    check("r0_bypass", bus.rs_data, 32'd0);
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    check("r0_after", bus.rs_data, 32'd0);

    // load-use stall on rt of an R-type
    fetch(32'h012B_5020, 32'h30);
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd11;
    fetch(32'h3409_FFFF, 32'h34);
    #1;
    check("stall_pc_write",  32'(bus.pc_write),  32'd0);
    check("stall_id_bubble", 32'(bus.id_bubble), 32'd1);
    tick();
    check("stall_hold_funct", 32'(bus.funct),    32'h20);
    check("stall_hold_pc",    bus.id_pc_plus4,   32'h30);
    check("stall_hold_valid", 32'(bus.id_valid), 32'd1);
    bus.ex_mem_read = 1'b0;
    #1;
    check("unstall_pc_write", 32'(bus.pc_write),  32'd1);
    check("unstall_bubble",   32'(bus.id_bubble), 32'd0);
    tick();
    check("after_stall_op", 32'(bus.opcode), 32'h0d);

    // ori does not use rt; ex_rt = 0 never stalls
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9;
    #1;
    check("no_rt_use", 32'(bus.pc_write), 32'd1);
    bus.ex_rt = 5'd0;
    #1;
    check("ex_rt_zero", 32'(bus.pc_write), 32'd1);
    bus.ex_mem_read = 1'b0;

    // flush wins over stall
    fetch(32'h012B_5020, 32'h40);
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.flush = 1'b1;
    #1;
    check("flush_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    bus.flush = 1'b0; bus.ex_mem_read = 1'b0;
    check("flush_valid",  32'(bus.id_valid),  32'd0);
    check("flush_opcode", 32'(bus.funct),     32'd0);
    check("flush_bubble", 32'(bus.id_bubble), 32'd1);
    check("flush_pc",     bus.id_pc_plus4,    32'h40);

    // asynchronous reset mid-stream
    fetch(32'h012B_5020, 32'h44);
    tick();
    check("pre_rst_rs_data", bus.rs_data, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid",   32'(bus.id_valid),  32'd0);
    check("arst_rs_data", bus.rs_data,        32'd0);
    check("arst_bubble",  32'(bus.id_bubble), 32'd1);
    tick();
    rst_n = 1'b1;
    fetch(32'h012B_5020, 32'h50);
    tick();
    check("post_rst_valid",   32'(bus.id_valid), 32'd1);
    check("post_rst_rs_data", bus.rs_data,       32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
